// File: rtl/serdes_channel_tx_kgen.sv
// serdes_channel_tx_kgen: framed TX word generator for one serdes channel.
// Inserts a K (comma/control) word every P+1 cycles, where P comes from the
// line rate code, and tracks a 0..149 hyperframe number across K words.
// C_CHANNEL_FOR_CPRI_TDM selects the CPRI (0) or TDM (1) period table.
// Optional feature: define SERDES_TX_KGEN_ERR_INJ_EN to let I_k_err_inj
// suppress the next scheduled K word (fault injection for link testing).
module serdes_channel_tx_kgen #(
    parameter int unsigned C_CHANNEL_FOR_CPRI_TDM = 0
) (
    input  logic        I_serdes_tx_clk,
    input  logic        I_serdes_tx_rst,
    input  logic [3:0]  I_serdes_rate,
    input  logic        I_8b10b_or_64b66b_sel,
    input  logic        I_tx_en,
    input  logic [63:0] I_tx_data,
    input  logic        I_k_err_inj,
    output logic [63:0] O_serdes_tx_data,
    output logic [7:0]  O_serdes_tx_k_flag,
    output logic        O_tx_kpos,
    output logic [7:0]  O_tx_hfn
);

    localparam int unsigned DATA_W  = 64;
    localparam int unsigned KF_W    = 8;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned HFN_W   = 8;
    localparam int unsigned RATE_W  = 4;
    localparam int unsigned RATE_MAX = 9;
    localparam int unsigned HFN_MAX = 149;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [RATE_W-1:0]   rate_q;
    logic                mode_q;
    logic                seen_k_q;

    logic [RATE_W-1:0]   rate_in;
    logic [CNT_W-1:0]    period;
    logic                cfg_chg;
    logic                emit;
    logic                k_slot;
    logic                k_supp;

    // Map a clamped rate code to the K period for the selected protocol family.
    function automatic logic [CNT_W-1:0] period_of(input logic [RATE_W-1:0] r);
        logic [CNT_W-1:0] p;
        p = '0;
        if (C_CHANNEL_FOR_CPRI_TDM != 0) begin
            case (r)
                4'd0:    p = CNT_W'(3);
                4'd1:    p = CNT_W'(7);
                4'd2:    p = CNT_W'(9);
                4'd3:    p = CNT_W'(15);
                4'd4:    p = CNT_W'(19);
                4'd5:    p = CNT_W'(31);
                4'd6:    p = CNT_W'(31);
                4'd7:    p = CNT_W'(39);
                4'd8:    p = CNT_W'(47);
                default: p = CNT_W'(95);
            endcase
        end else begin
            case (r)
                4'd0:    p = CNT_W'(1023);
                4'd1:    p = CNT_W'(2047);
                4'd2:    p = CNT_W'(2559);
                4'd3:    p = CNT_W'(4095);
                4'd4:    p = CNT_W'(5119);
                4'd5:    p = CNT_W'(8191);
                4'd6:    p = CNT_W'(8191);
                4'd7:    p = CNT_W'(10239);
                4'd8:    p = CNT_W'(12287);
                default: p = CNT_W'(24575);
            endcase
        end
        return p;
    endfunction

    // Codes above 9 alias to 9, so 12 vs 9 is not treated as a rate change.
    assign rate_in = (I_serdes_rate > RATE_W'(RATE_MAX)) ? RATE_W'(RATE_MAX) : I_serdes_rate;
    assign period  = period_of(rate_q);
    assign cfg_chg = (rate_q != rate_in) || (mode_q != I_8b10b_or_64b66b_sel);
    // Enable drop and reconfiguration win over word emission in the same cycle.
    assign emit    = (state == ST_RUN) && I_tx_en && !cfg_chg;
    assign k_slot  = emit && (cnt == '0);

`ifdef SERDES_TX_KGEN_ERR_INJ_EN
    logic pend_q;

    // Pending-injection flag: armed by a pulse, consumed by the next K slot.
    always_ff @(posedge I_serdes_tx_clk) begin
        if (I_serdes_tx_rst) begin
            pend_q <= 1'b0;
        end else if (k_slot && pend_q) begin
            pend_q <= 1'b0;
        end else if (I_k_err_inj) begin
            pend_q <= 1'b1;
        end
    end

    assign k_supp = pend_q;
`else
    logic unused_k_err_inj;

    assign unused_k_err_inj = I_k_err_inj;
    assign k_supp           = 1'b0;
`endif

    // Control FSM, K counter and registered output word.
    always_ff @(posedge I_serdes_tx_clk) begin
        if (I_serdes_tx_rst) begin
            state              <= ST_IDLE;
            cnt                <= '0;
            rate_q             <= '0;
            mode_q             <= 1'b0;
            seen_k_q           <= 1'b0;
            O_serdes_tx_data   <= '0;
            O_serdes_tx_k_flag <= '0;
            O_tx_kpos          <= 1'b0;
            O_tx_hfn           <= '0;
        end else begin
            O_serdes_tx_data   <= '0;
            O_serdes_tx_k_flag <= '0;
            O_tx_kpos          <= 1'b0;
            O_tx_hfn           <= '0;
            case (state)
                ST_IDLE: begin
                    if (I_tx_en) begin
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    rate_q   <= rate_in;
                    mode_q   <= I_8b10b_or_64b66b_sel;
                    cnt      <= '0;
                    seen_k_q <= 1'b0;
                    state    <= ST_RUN;
                end
                ST_RUN: begin
                    if (!I_tx_en) begin
                        state <= ST_IDLE;
                    end else if (cfg_chg) begin
                        state <= ST_START;
                    end else begin
                        cnt              <= (cnt == period) ? '0 : cnt + CNT_W'(1);
                        O_serdes_tx_data <= I_tx_data;
                        O_tx_hfn         <= O_tx_hfn;
                        if (k_slot) begin
                            seen_k_q <= 1'b1;
                            if (seen_k_q) begin
                                O_tx_hfn <= (O_tx_hfn == HFN_W'(HFN_MAX)) ? '0
                                                                          : O_tx_hfn + HFN_W'(1);
                            end
                            if (!k_supp) begin
                                O_tx_kpos <= 1'b1;
                                if (mode_q) begin
                                    O_serdes_tx_data   <= {8'hFD, I_tx_data[DATA_W-9:0]};
                                    O_serdes_tx_k_flag <= KF_W'(8'h80);
                                end else begin
                                    O_serdes_tx_data   <= {I_tx_data[DATA_W-1:8], 8'hBC};
                                    O_serdes_tx_k_flag <= KF_W'(8'h01);
                                end
                            end
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serdes_channel_tx_kgen.sv
// Bench for serdes_channel_tx_kgen: a CPRI and a TDM instance share stimulus
// and are compared every cycle against a frame-index reference model.
module tb_serdes_channel_tx_kgen;

    logic        clk;
    logic        rst;
    logic [3:0]  rate;
    logic        sel;
    logic        en;
    logic [63:0] data;
    logic        inj;

    logic [63:0] c_data, t_data;
    logic [7:0]  c_kf, t_kf;
    logic        c_kpos, t_kpos;
    logic [7:0]  c_hfn, t_hfn;

    wire [80:0] act0 = {c_data, c_kf, c_kpos, c_hfn};
    wire [80:0] act1 = {t_data, t_kf, t_kpos, t_hfn};

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    int unsigned cpri_p [10] = '{1023, 2047, 2559, 4095, 5119, 8191, 8191, 10239, 12287, 24575};
    int unsigned tdm_p  [10] = '{3, 7, 9, 15, 19, 31, 31, 39, 47, 95};

    // Reference model: state 0 idle, 1 start, 2 run; m_t = words emitted in RUN.
    int          m_st   [2];
    int unsigned m_t    [2];
    int          m_rate [2];
    logic        m_mode [2];
    logic        m_pend [2];
    logic [80:0] m_exp  [2];

`ifdef SERDES_TX_KGEN_ERR_INJ_EN
    localparam int unsigned INJ_GAP  = 2048;
    localparam int unsigned INJ_HSTP = 2;
`else
    localparam int unsigned INJ_GAP  = 1024;
    localparam int unsigned INJ_HSTP = 1;
`endif

    serdes_channel_tx_kgen #(.C_CHANNEL_FOR_CPRI_TDM(0)) u_cpri (
        .I_serdes_tx_clk       (clk),
        .I_serdes_tx_rst       (rst),
        .I_serdes_rate         (rate),
        .I_8b10b_or_64b66b_sel (sel),
        .I_tx_en               (en),
        .I_tx_data             (data),
        .I_k_err_inj           (inj),
        .O_serdes_tx_data      (c_data),
        .O_serdes_tx_k_flag    (c_kf),
        .O_tx_kpos             (c_kpos),
        .O_tx_hfn              (c_hfn)
    );

    serdes_channel_tx_kgen #(.C_CHANNEL_FOR_CPRI_TDM(1)) u_tdm (
        .I_serdes_tx_clk       (clk),
        .I_serdes_tx_rst       (rst),
        .I_serdes_rate         (rate),
        .I_8b10b_or_64b66b_sel (sel),
        .I_tx_en               (en),
        .I_tx_data             (data),
        .I_k_err_inj           (inj),
        .O_serdes_tx_data      (t_data),
        .O_serdes_tx_k_flag    (t_kf),
        .O_tx_kpos             (t_kpos),
        .O_tx_hfn              (t_hfn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int clamp_rate(input logic [3:0] r);
        return (r > 4'd9) ? 9 : int'(r);
    endfunction

    // Expected registered outputs after one clock edge with the current inputs.
    function automatic void model_step();
        for (int i = 0; i < 2; i++) begin
            int unsigned p1;
            int unsigned fr;
            logic        slot;
            logic        sup;
            logic        kout;
            logic [63:0] d;
            logic [7:0]  kf;
            logic [7:0]  h;
            d = '0; kf = '0; kout = 1'b0; h = '0; sup = 1'b0; slot = 1'b0;
            if (rst) begin
                m_st[i] = 0; m_t[i] = 0; m_pend[i] = 1'b0;
            end else begin
                case (m_st[i])
                    0: if (en) m_st[i] = 1;
                    1: begin
                        m_rate[i] = clamp_rate(rate);
                        m_mode[i] = sel;
                        m_t[i]    = 0;
                        m_st[i]   = 2;
                    end
                    default: begin
                        if (!en) m_st[i] = 0;
                        else if (clamp_rate(rate) != m_rate[i] || sel != m_mode[i]) m_st[i] = 1;
                        else begin
                            p1   = ((i == 0) ? cpri_p[m_rate[i]] : tdm_p[m_rate[i]]) + 1;
                            slot = (m_t[i] % p1) == 0;
                            fr   = m_t[i] / p1;
                            h    = 8'(fr % 150);
`ifdef SERDES_TX_KGEN_ERR_INJ_EN
                            sup  = slot && m_pend[i];
`endif
                            d    = data;
                            if (slot && !sup) begin
                                kout = 1'b1;
                                if (!m_mode[i]) begin d[7:0] = 8'hBC; kf = 8'h01; end
                                else begin d[63:56] = 8'hFD; kf = 8'h80; end
                            end
                            m_t[i] = m_t[i] + 1;
                        end
                    end
                endcase
`ifdef SERDES_TX_KGEN_ERR_INJ_EN
                if (slot && m_pend[i]) m_pend[i] = 1'b0;
                else if (inj) m_pend[i] = 1'b1;
`endif
            end
            m_exp[i] = {d, kf, kout, h};
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; rate = 4'd0; sel = 1'b0; inj = 1'b0; data = '0;
        for (int n = 0; n < 4; n++) begin
            data = {$urandom, $urandom};
            tick();
            n_chk++;
            if (act0 !== 81'd0) begin n_fail++; $display("FAIL reset_cpri: got %h want 0", act0); end
            n_chk++;
            if (act1 !== 81'd0) begin n_fail++; $display("FAIL reset_tdm: got %h want 0", act1); end
        end
        rst = 1'b0; en = 1'b0;
        tick();
    endtask

    task automatic test_cpri_rate0_8b10b();
        int s, last, nk;
        en = 1'b0; tick(); tick();
        rate = 4'd0; sel = 1'b0; en = 1'b1;
        data = {$urandom, $urandom};
        tick(); s = cyc; nk = 0; last = 0;
        for (int n = 0; n < 3 * 1024 + 10; n++) begin
            data = {$urandom, $urandom};
            tick();
            n_chk++;
            if (act0 !== m_exp[0]) begin n_fail++; $display("FAIL r0_cpri_word@%0d: got %h want %h", cyc, act0, m_exp[0]); end
            n_chk++;
            if (act1 !== m_exp[1]) begin n_fail++; $display("FAIL r0_tdm_word@%0d: got %h want %h", cyc, act1, m_exp[1]); end
            if (c_kpos) begin
                n_chk++;
                if (nk == 0 && cyc != s + 2) begin n_fail++; $display("FAIL r0_first_k: got cycle %0d want %0d", cyc, s + 2); end
                if (nk != 0 && cyc - last != 1024) begin n_fail++; $display("FAIL r0_k_gap: got %0d want 1024", cyc - last); end
                n_chk++;
                if (c_data[7:0] !== 8'hBC || c_kf !== 8'h01) begin
                    n_fail++; $display("FAIL r0_k_word: got byte %h flag %h want bc 01", c_data[7:0], c_kf);
                end
                nk++; last = cyc;
            end
        end
        n_chk++;
        if (nk != 4) begin n_fail++; $display("FAIL r0_k_count: got %0d want 4", nk); end
    endtask

    task automatic test_rate9_64b66b();
        int s, last, nk, tlast, tk;
        en = 1'b0; tick(); tick();
        rate = 4'd9; sel = 1'b1; en = 1'b1;
        tick(); s = cyc; nk = 0; last = 0; tk = 0; tlast = 0;
        for (int n = 0; n < 24576 + 8; n++) begin
            data = {$urandom, $urandom};
            tick();
            n_chk++;
            if (act0 !== m_exp[0]) begin n_fail++; $display("FAIL r9_cpri_word@%0d: got %h want %h", cyc, act0, m_exp[0]); end
            n_chk++;
            if (act1 !== m_exp[1]) begin n_fail++; $display("FAIL r9_tdm_word@%0d: got %h want %h", cyc, act1, m_exp[1]); end
            if (c_kpos) begin
                n_chk++;
                if (nk == 0 && cyc != s + 2) begin n_fail++; $display("FAIL r9_first_k: got cycle %0d want %0d", cyc, s + 2); end
                if (nk != 0 && cyc - last != 24576) begin n_fail++; $display("FAIL r9_k_gap: got %0d want 24576", cyc - last); end
                n_chk++;
                if (c_data[63:56] !== 8'hFD || c_kf !== 8'h80) begin
                    n_fail++; $display("FAIL r9_k_word: got byte %h flag %h want fd 80", c_data[63:56], c_kf);
                end
                nk++; last = cyc;
            end
            if (t_kpos) begin
                if (tk != 0) begin
                    n_chk++;
                    if (cyc - tlast != 96) begin n_fail++; $display("FAIL r9_tdm_gap: got %0d want 96", cyc - tlast); end
                end
                tk++; tlast = cyc;
            end
        end
        n_chk++;
        if (nk != 2) begin n_fail++; $display("FAIL r9_k_count: got %0d want 2", nk); end
    endtask

    task automatic test_rate12_alias();
        int s, tlast, tk;
        en = 1'b0; tick(); tick();
        rate = 4'd12; sel = 1'b1; en = 1'b1;
        tick(); s = cyc; tk = 0; tlast = 0;
        for (int n = 0; n < 300; n++) begin
            data = {$urandom, $urandom};
            tick();
            n_chk++;
            if (act1 !== m_exp[1]) begin n_fail++; $display("FAIL r12_tdm_word@%0d: got %h want %h", cyc, act1, m_exp[1]); end
            n_chk++;
            if (act0 !== m_exp[0]) begin n_fail++; $display("FAIL r12_cpri_word@%0d: got %h want %h", cyc, act0, m_exp[0]); end
            if (t_kpos) begin
                n_chk++;
                if (tk == 0 && cyc != s + 2) begin n_fail++; $display("FAIL r12_first_k: got cycle %0d want %0d", cyc, s + 2); end
                if (tk != 0 && cyc - tlast != 96) begin n_fail++; $display("FAIL r12_gap: got %0d want 96", cyc - tlast); end
                tk++; tlast = cyc;
            end
        end
        n_chk++;
        if (tk != 4) begin n_fail++; $display("FAIL r12_k_count: got %0d want 4", tk); end
    endtask

    task automatic test_hfn_wrap();
        int tlast, tk;
        en = 1'b0; tick(); tick();
        rate = 4'd0; sel = 1'b0; en = 1'b1;
        tick(); tk = 0; tlast = 0;
        for (int n = 0; n < 151 * 4 + 20 && tk < 151; n++) begin
            data = {$urandom, $urandom};
            tick();
            n_chk++;
            if (act1 !== m_exp[1]) begin n_fail++; $display("FAIL hfn_tdm_word@%0d: got %h want %h", cyc, act1, m_exp[1]); end
            if (t_kpos) begin
                n_chk++;
                if (int'(t_hfn) != tk % 150) begin n_fail++; $display("FAIL hfn_seq: got %0d want %0d", t_hfn, tk % 150); end
                if (tk != 0) begin
                    n_chk++;
                    if (cyc - tlast != 4) begin n_fail++; $display("FAIL hfn_gap: got %0d want 4", cyc - tlast); end
                end
                tk++; tlast = cyc;
            end
        end
        n_chk++;
        if (tk != 151) begin n_fail++; $display("FAIL hfn_k_count: got %0d want 151", tk); end
    endtask

    task automatic test_rate_change();
        int s, last, nk;
        en = 1'b0; tick(); tick();
        rate = 4'd0; sel = 1'b0; en = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            data = {$urandom, $urandom};
            tick();
            n_chk++;
            if (act0 !== m_exp[0]) begin n_fail++; $display("FAIL rc_pre_word@%0d: got %h want %h", cyc, act0, m_exp[0]); end
        end
        rate = 4'd1;
        data = {$urandom, $urandom};
        tick(); s = cyc;
        n_chk++;
        if (act0 !== 81'd0) begin n_fail++; $display("FAIL rc_change_edge: got %h want 0", act0); end
        data = {$urandom, $urandom};
        tick();
        n_chk++;
        if (act0 !== 81'd0) begin n_fail++; $display("FAIL rc_start_cycle: got %h want 0", act0); end
        nk = 0; last = 0;
        for (int n = 0; n < 2 * 2048 + 10; n++) begin
            data = {$urandom, $urandom};
            tick();
            n_chk++;
            if (act0 !== m_exp[0]) begin n_fail++; $display("FAIL rc_cpri_word@%0d: got %h want %h", cyc, act0, m_exp[0]); end
            n_chk++;
            if (act1 !== m_exp[1]) begin n_fail++; $display("FAIL rc_tdm_word@%0d: got %h want %h", cyc, act1, m_exp[1]); end
            if (c_kpos) begin
                n_chk++;
                if (nk == 0 && (cyc != s + 2 || c_hfn !== 8'd0)) begin
                    n_fail++; $display("FAIL rc_first_k: got cycle %0d hfn %0d want %0d hfn 0", cyc, c_hfn, s + 2);
                end
                if (nk != 0 && (cyc - last != 2048 || int'(c_hfn) != nk)) begin
                    n_fail++; $display("FAIL rc_gap: got %0d hfn %0d want 2048 hfn %0d", cyc - last, c_hfn, nk);
                end
                nk++; last = cyc;
            end
        end
        n_chk++;
        if (nk != 3) begin n_fail++; $display("FAIL rc_k_count: got %0d want 3", nk); end
    endtask

    task automatic test_reset_mid_run();
        int s, nk;
        rate = 4'd0; sel = 1'b0; en = 1'b1;
        for (int n = 0; n < 50; n++) begin
            data = {$urandom, $urandom};
            tick();
        end
        rst = 1'b1;
        tick();
        n_chk++;
        if (act0 !== 81'd0) begin n_fail++; $display("FAIL rst_mid_cpri: got %h want 0", act0); end
        n_chk++;
        if (act1 !== 81'd0) begin n_fail++; $display("FAIL rst_mid_tdm: got %h want 0", act1); end
        rst = 1'b0;
        tick(); s = cyc; nk = 0;
        for (int n = 0; n < 20; n++) begin
            data = {$urandom, $urandom};
            tick();
            n_chk++;
            if (act0 !== m_exp[0]) begin n_fail++; $display("FAIL rst_cpri_word@%0d: got %h want %h", cyc, act0, m_exp[0]); end
            if (c_kpos) begin
                n_chk++;
                if (nk == 0 && (cyc != s + 2 || c_hfn !== 8'd0)) begin
                    n_fail++; $display("FAIL rst_resume_k: got cycle %0d hfn %0d want %0d hfn 0", cyc, c_hfn, s + 2);
                end
                nk++;
            end
        end
        n_chk++;
        if (nk != 1) begin n_fail++; $display("FAIL rst_k_count: got %0d want 1", nk); end
    endtask

    task automatic test_err_inj();
        int s, last, h0, nk;
        en = 1'b0; tick(); tick();
        rate = 4'd0; sel = 1'b0; en = 1'b1;
        tick(); s = cyc;
        for (int n = 0; n < 102; n++) begin
            data = {$urandom, $urandom};
            tick();
            n_chk++;
            if (act0 !== m_exp[0]) begin n_fail++; $display("FAIL inj_pre_word@%0d: got %h want %h", cyc, act0, m_exp[0]); end
        end
        last = s + 2; h0 = 0; nk = 0;
        inj = 1'b1;
        tick();
        inj = 1'b0;
        for (int n = 0; n < 2100 && nk == 0; n++) begin
            data = {$urandom, $urandom};
            tick();
            n_chk++;
            if (act0 !== m_exp[0]) begin n_fail++; $display("FAIL inj_cpri_word@%0d: got %h want %h", cyc, act0, m_exp[0]); end
            n_chk++;
            if (act1 !== m_exp[1]) begin n_fail++; $display("FAIL inj_tdm_word@%0d: got %h want %h", cyc, act1, m_exp[1]); end
            if (c_kpos) begin
                n_chk++;
                if (cyc - last != int'(INJ_GAP) || int'(c_hfn) - h0 != int'(INJ_HSTP)) begin
                    n_fail++;
                    $display("FAIL inj_gap: got gap %0d hfn step %0d want %0d step %0d",
                             cyc - last, int'(c_hfn) - h0, INJ_GAP, INJ_HSTP);
                end
                nk++;
            end
        end
        n_chk++;
        if (nk != 1) begin n_fail++; $display("FAIL inj_k_seen: got %0d want 1", nk); end
    endtask

    task automatic test_back_to_back();
        en = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 99) < 3) en = ~en;
            if ($urandom_range(0, 99) < 2) rate = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) < 2) sel = ~sel;
            data = {$urandom, $urandom};
            inj = ($urandom_range(0, 99) < 1);
            tick();
            n_chk++;
            if (act0 !== m_exp[0]) begin n_fail++; $display("FAIL b2b_cpri_word@%0d: got %h want %h", cyc, act0, m_exp[0]); end
            n_chk++;
            if (act1 !== m_exp[1]) begin n_fail++; $display("FAIL b2b_tdm_word@%0d: got %h want %h", cyc, act1, m_exp[1]); end
        end
        inj = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; rate = '0; sel = 1'b0; data = '0; inj = 1'b0;
        test_reset();
        test_cpri_rate0_8b10b();
        test_rate9_64b66b();
        test_rate12_alias();
        test_hfn_wrap();
        test_rate_change();
        test_reset_mid_run();
        test_err_inj();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
